// File: rtl/lockstep_pkg.sv
// Shared types for the pipeline lockstep checker: FSM states, error codes and channel-index width.
package lockstep_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRun   = 3'd1,
        StDrain = 3'd2,
        StDone  = 3'd3,
        StFail  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ErrNone     = 3'd0,
        ErrMismatch = 3'd1,
        ErrOverflow = 3'd2,
        ErrTimeout  = 3'd3,
        ErrOrphan   = 3'd4
    } err_code_t;

    // Channel index width, never narrower than one bit.
    function automatic int unsigned ch_w(input int unsigned num_ch);
        if (num_ch <= 1) return 1;
        return $clog2(num_ch);
    endfunction

endpackage

// File: rtl/pipe_lockstep_checker_if.sv
// Result-stream bundle from the pipelined cpu (dut_*) and the golden model (mdl_*).
// The optional cmp_mask bus exists only when LOCKSTEP_CMP_MASK_EN is defined.
interface pipe_lockstep_checker_if #(
    parameter int unsigned NUM_CH = 6,
    parameter int unsigned DATA_W = 32
);

    logic [NUM_CH-1:0]        dut_valid;
    logic [NUM_CH*DATA_W-1:0] dut_data;
    logic [NUM_CH-1:0]        mdl_valid;
    logic [NUM_CH*DATA_W-1:0] mdl_data;
    logic                     dut_hlt;
    logic                     mdl_hlt;
`ifdef LOCKSTEP_CMP_MASK_EN
    logic [NUM_CH*DATA_W-1:0] cmp_mask;
`endif

    modport master (
`ifdef LOCKSTEP_CMP_MASK_EN
        output cmp_mask,
`endif
        output dut_valid, dut_data, mdl_valid, mdl_data, dut_hlt, mdl_hlt
    );

    modport slave (
`ifdef LOCKSTEP_CMP_MASK_EN
        input cmp_mask,
`endif
        input dut_valid, dut_data, mdl_valid, mdl_data, dut_hlt, mdl_hlt
    );

endinterface

// File: rtl/lc_skew_fifo.sv
// Single-clock skew FIFO; head is zero while empty, a push is visible at the head next cycle.
module lc_skew_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_en, rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A full FIFO may accept a push only when its head leaves in the same cycle.
    assign wr_en = push && (!full || pop) && !flush;
    assign rd_en = pop && !empty && !flush;
    assign head  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/pipe_lockstep_checker.sv
// Run-time lockstep checker comparing per-stage DUT and model result streams through skew FIFOs.
// Define LOCKSTEP_CMP_MASK_EN to enable the per-bit don't-care compare mask.
module pipe_lockstep_checker
    import lockstep_pkg::*;
#(
    parameter int unsigned NUM_CH  = 6,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1000000,
    parameter int unsigned CYC_W   = 32,
    localparam int unsigned CH_W   = ch_w(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    pipe_lockstep_checker_if.slave bus,
    output logic [2:0]           state,
    output logic                 done,
    output logic                 pass,
    output logic                 err,
    output logic [2:0]           err_code,
    output logic [CH_W-1:0]      err_ch,
    output logic [DATA_W-1:0]    err_dut_val,
    output logic [DATA_W-1:0]    err_mdl_val,
    output logic [CYC_W-1:0]     err_cycle,
    output logic [CYC_W-1:0]     cmp_count
);

    localparam int unsigned CW1 = CYC_W + 1;

    state_t            state_q, state_d;
    err_code_t         err_code_q, err_code_d, err_sel_code;
    logic [CH_W-1:0]   err_ch_q, err_ch_d, err_sel_ch;
    logic [DATA_W-1:0] err_dut_val_q, err_dut_val_d, err_mdl_val_q, err_mdl_val_d;
    logic [CYC_W-1:0]  err_cycle_q, err_cycle_d, cyc_q, cyc_d;
    logic [CYC_W-1:0]  cmp_count_q, cmp_count_d, wdog_q, wdog_d;
    logic [CYC_W-1:0]  cyc_inc, wdog_inc, cmp_sat;
    logic [CYC_W:0]    cmp_sum;
    logic              dut_hlt_q, dut_hlt_d, mdl_hlt_q, mdl_hlt_d;
    logic              active, flush, all_empty, timeout_hit, orphan_hit, err_hit;

    logic [NUM_CH-1:0] dut_push, mdl_push, dut_full, mdl_full, dut_empty, mdl_empty;
    logic [NUM_CH-1:0] cmp_v, miscmp, match_v, ovf, nonempty;
    logic [NUM_CH-1:0][DATA_W-1:0] dut_head, mdl_head, diff;

    function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) idx = CH_W'(i);
        end
        return idx;
    endfunction

    assign active    = (state_q == StRun) || (state_q == StDrain);
    // FIFOs are held empty in IDLE so every session starts clean.
    assign flush     = (state_q == StIdle);
    assign dut_push  = active ? bus.dut_valid : '0;
    assign mdl_push  = active ? bus.mdl_valid : '0;
    assign cmp_v     = active ? (~dut_empty & ~mdl_empty) : '0;
    assign match_v   = cmp_v & ~miscmp;
    assign ovf       = (dut_push & dut_full & ~cmp_v) | (mdl_push & mdl_full & ~cmp_v);
    assign nonempty  = ~(dut_empty & mdl_empty);
    assign all_empty = (nonempty == '0);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        lc_skew_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .push  (dut_push[c]),
            .pop   (cmp_v[c]),
            .wdata (bus.dut_data[c*DATA_W +: DATA_W]),
            .head  (dut_head[c]),
            .full  (dut_full[c]),
            .empty (dut_empty[c])
        );
        lc_skew_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mdl_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .push  (mdl_push[c]),
            .pop   (cmp_v[c]),
            .wdata (bus.mdl_data[c*DATA_W +: DATA_W]),
            .head  (mdl_head[c]),
            .full  (mdl_full[c]),
            .empty (mdl_empty[c])
        );
`ifdef LOCKSTEP_CMP_MASK_EN
        assign diff[c] = (dut_head[c] ^ mdl_head[c]) & bus.cmp_mask[c*DATA_W +: DATA_W];
`else
        assign diff[c] = dut_head[c] ^ mdl_head[c];
`endif
        assign miscmp[c] = cmp_v[c] && (diff[c] != '0);
    end

    assign timeout_hit = (state_q == StRun) && (wdog_q >= CYC_W'(TIMEOUT));
    assign orphan_hit  = (state_q == StDrain) && (cmp_v == '0) && !all_empty;

    always_comb begin
        err_hit      = 1'b1;
        err_sel_code = ErrNone;
        err_sel_ch   = '0;
        if (|miscmp) begin
            err_sel_code = ErrMismatch;
            err_sel_ch   = lowest_set(miscmp);
        end else if (|ovf) begin
            err_sel_code = ErrOverflow;
            err_sel_ch   = lowest_set(ovf);
        end else if (timeout_hit) begin
            err_sel_code = ErrTimeout;
        end else if (orphan_hit) begin
            err_sel_code = ErrOrphan;
            err_sel_ch   = lowest_set(nonempty);
        end else begin
            err_hit = 1'b0;
        end
    end

    // Saturating counter steps.
    always_comb begin
        cyc_inc  = (cyc_q == '1) ? cyc_q : cyc_q + CYC_W'(1);
        wdog_inc = (wdog_q == '1) ? wdog_q : wdog_q + CYC_W'(1);
        cmp_sum  = {1'b0, cmp_count_q} + CW1'($countones(match_v));
        cmp_sat  = cmp_sum[CYC_W] ? '1 : cmp_sum[CYC_W-1:0];
    end

    always_comb begin
        state_d       = state_q;
        err_code_d    = err_code_q;
        err_ch_d      = err_ch_q;
        err_dut_val_d = err_dut_val_q;
        err_mdl_val_d = err_mdl_val_q;
        err_cycle_d   = err_cycle_q;
        cyc_d         = cyc_q;
        cmp_count_d   = cmp_count_q;
        wdog_d        = wdog_q;
        dut_hlt_d     = dut_hlt_q;
        mdl_hlt_d     = mdl_hlt_q;
        case (state_q)
            StIdle: begin
                if (en) begin
                    state_d       = StRun;
                    err_code_d    = ErrNone;
                    err_ch_d      = '0;
                    err_dut_val_d = '0;
                    err_mdl_val_d = '0;
                    err_cycle_d   = '0;
                    cyc_d         = '0;
                    cmp_count_d   = '0;
                    wdog_d        = '0;
                    dut_hlt_d     = 1'b0;
                    mdl_hlt_d     = 1'b0;
                end
            end
            StRun, StDrain: begin
                cyc_d       = cyc_inc;
                cmp_count_d = cmp_sat;
                if (|cmp_v)                wdog_d = '0;
                else if (state_q == StRun) wdog_d = wdog_inc;
                dut_hlt_d = dut_hlt_q | bus.dut_hlt;
                mdl_hlt_d = mdl_hlt_q | bus.mdl_hlt;
                if (!en) begin
                    state_d = StIdle;
                end else if (err_hit) begin
                    state_d       = StFail;
                    err_code_d    = err_sel_code;
                    err_ch_d      = err_sel_ch;
                    err_dut_val_d = dut_head[err_sel_ch];
                    err_mdl_val_d = mdl_head[err_sel_ch];
                    err_cycle_d   = cyc_q;
                end else if ((state_q == StRun) && dut_hlt_q && mdl_hlt_q) begin
                    state_d = StDrain;
                end else if ((state_q == StDrain) && all_empty) begin
                    state_d = StDone;
                end
            end
            StDone, StFail: begin
                if (!en) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            err_code_q    <= ErrNone;
            err_ch_q      <= '0;
            err_dut_val_q <= '0;
            err_mdl_val_q <= '0;
            err_cycle_q   <= '0;
            cyc_q         <= '0;
            cmp_count_q   <= '0;
            wdog_q        <= '0;
            dut_hlt_q     <= 1'b0;
            mdl_hlt_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_code_q    <= err_code_d;
            err_ch_q      <= err_ch_d;
            err_dut_val_q <= err_dut_val_d;
            err_mdl_val_q <= err_mdl_val_d;
            err_cycle_q   <= err_cycle_d;
            cyc_q         <= cyc_d;
            cmp_count_q   <= cmp_count_d;
            wdog_q        <= wdog_d;
            dut_hlt_q     <= dut_hlt_d;
            mdl_hlt_q     <= mdl_hlt_d;
        end
    end

    assign state       = state_q;
    assign pass        = (state_q == StDone);
    assign err         = (state_q == StFail);
    assign done        = pass | err;
    assign err_code    = err_code_q;
    assign err_ch      = err_ch_q;
    assign err_dut_val = err_dut_val_q;
    assign err_mdl_val = err_mdl_val_q;
    assign err_cycle   = err_cycle_q;
    assign cmp_count   = cmp_count_q;

endmodule

// File: tb/tb_pipe_lockstep_checker.sv
// Directed bench for pipe_lockstep_checker with TIMEOUT shortened to 16 cycles.
module tb_pipe_lockstep_checker;

    localparam int unsigned NUM_CH  = 6;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CYC_W   = 32;
    localparam int unsigned CH_W    = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [2:0]        state;
    logic              done, pass, err;
    logic [2:0]        err_code;
    logic [CH_W-1:0]   err_ch;
    logic [DATA_W-1:0] err_dut_val, err_mdl_val;
    logic [CYC_W-1:0]  err_cycle, cmp_count;

    int vectors     = 0;
    int miscompares = 0;

    pipe_lockstep_checker_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    pipe_lockstep_checker #(
        .NUM_CH  (NUM_CH),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .CYC_W   (CYC_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .bus         (bus),
        .state       (state),
        .done        (done),
        .pass        (pass),
        .err         (err),
        .err_code    (err_code),
        .err_ch      (err_ch),
        .err_dut_val (err_dut_val),
        .err_mdl_val (err_mdl_val),
        .err_cycle   (err_cycle),
        .cmp_count   (cmp_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.dut_valid = '0;
        bus.mdl_valid = '0;
        bus.dut_data  = '0;
        bus.mdl_data  = '0;
        bus.dut_hlt   = 1'b0;
        bus.mdl_hlt   = 1'b0;
    endtask

    task automatic set_dut(input int ch, input logic [DATA_W-1:0] v);
        bus.dut_valid[ch]                 = 1'b1;
        bus.dut_data[ch*DATA_W +: DATA_W] = v;
    endtask

    task automatic set_mdl(input int ch, input logic [DATA_W-1:0] v);
        bus.mdl_valid[ch]                 = 1'b1;
        bus.mdl_data[ch*DATA_W +: DATA_W] = v;
    endtask

    // Leaves the bench in the first RUN cycle (session cycle 0).
    task automatic start_session();
        en = 1'b1;
        tick();
    endtask

    task automatic end_session();
        clear_inputs();
        en = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        clear_inputs();
        tick();
        tick();
        vectors++;
        if (state !== 3'd0 || done !== 1'b0 || pass !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status: got state=%0d done=%0b pass=%0b err=%0b, want 0 0 0 0",
                     state, done, pass, err);
        end
        vectors++;
        if (err_code !== 3'd0 || err_ch !== '0 || err_cycle !== '0 || cmp_count !== '0) begin
            miscompares++;
            $display("FAIL reset_regs: got code=%0d ch=%0d cyc=%0d cnt=%0d, want all 0",
                     err_code, err_ch, err_cycle, cmp_count);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (state !== 3'd0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got state=%0d, want 0", state);
        end
    endtask

    task automatic test_matched();
        start_session();
        set_dut(0, 32'h1234);
        set_mdl(0, 32'h1234);
        tick();
        clear_inputs();
        vectors++;
        if (cmp_count !== 32'd0) begin
            miscompares++;
            $display("FAIL match_cnt_early: got %0d, want 0", cmp_count);
        end
        tick();
        vectors++;
        if (cmp_count !== 32'd1) begin
            miscompares++;
            $display("FAIL match_cnt: got %0d, want 1", cmp_count);
        end
        bus.dut_hlt = 1'b1;
        bus.mdl_hlt = 1'b1;
        tick();
        clear_inputs();
        tick();
        vectors++;
        if (state !== 3'd2) begin
            miscompares++;
            $display("FAIL match_drain: got state=%0d, want 2", state);
        end
        tick();
        vectors++;
        if (state !== 3'd3 || pass !== 1'b1 || err !== 1'b0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL match_done: got state=%0d pass=%0b err=%0b done=%0b, want 3 1 0 1",
                     state, pass, err, done);
        end
        end_session();
        vectors++;
        if (state !== 3'd0 || pass !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL match_idle: got state=%0d pass=%0b done=%0b, want 0 0 0",
                     state, pass, done);
        end
    endtask

    task automatic test_multi_channel();
        start_session();
        for (int c = 0; c < int'(NUM_CH); c++) begin
            set_dut(c, 32'h11 * (c + 1));
            set_mdl(c, 32'h11 * (c + 1));
        end
        tick();
        for (int c = 0; c < int'(NUM_CH); c++) begin
            set_dut(c, 32'h2200 + c);
            set_mdl(c, 32'h2200 + c);
        end
        tick();
        clear_inputs();
        vectors++;
        if (cmp_count !== 32'd6) begin
            miscompares++;
            $display("FAIL multi_cnt_first: got %0d, want 6", cmp_count);
        end
        tick();
        vectors++;
        if (cmp_count !== 32'd12 || state !== 3'd1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL multi_cnt_second: got cnt=%0d state=%0d err=%0b, want 12 1 0",
                     cmp_count, state, err);
        end
        end_session();
    endtask

    task automatic test_skew();
        start_session();
        for (int k = 0; k < 12; k++) begin
            if (k == 8) begin
                vectors++;
                if (cmp_count !== 32'd4) begin
                    miscompares++;
                    $display("FAIL skew_cnt_mid: got %0d, want 4", cmp_count);
                end
            end
            clear_inputs();
            if (k < 8) set_dut(2, 32'hC0DE_0000 + k);
            if (k >= 3 && k < 11) set_mdl(2, 32'hC0DE_0000 + (k - 3));
            tick();
        end
        clear_inputs();
        vectors++;
        if (cmp_count !== 32'd8 || state !== 3'd1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL skew_final: got cnt=%0d state=%0d err=%0b, want 8 1 0",
                     cmp_count, state, err);
        end
        end_session();
    endtask

    task automatic test_mismatch();
        start_session();
        set_dut(3, 32'hAAAA);
        set_mdl(3, 32'hAAAB);
        set_dut(5, 32'h5);
        set_mdl(5, 32'h6);
        tick();
        clear_inputs();
        vectors++;
        if (state !== 3'd1) begin
            miscompares++;
            $display("FAIL mis_pre_state: got %0d, want 1", state);
        end
        tick();
        vectors++;
        if (state !== 3'd4 || err !== 1'b1 || pass !== 1'b0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL mis_status: got state=%0d err=%0b pass=%0b done=%0b, want 4 1 0 1",
                     state, err, pass, done);
        end
        vectors++;
        if (err_code !== 3'd1 || err_ch !== 3'd3 || err_cycle !== 32'd1) begin
            miscompares++;
            $display("FAIL mis_capture: got code=%0d ch=%0d cyc=%0d, want 1 3 1",
                     err_code, err_ch, err_cycle);
        end
        vectors++;
        if (err_dut_val !== 32'hAAAA || err_mdl_val !== 32'hAAAB) begin
            miscompares++;
            $display("FAIL mis_values: got dut=%0h mdl=%0h, want aaaa aaab",
                     err_dut_val, err_mdl_val);
        end
        tick();
        tick();
        vectors++;
        if (state !== 3'd4 || err !== 1'b1 || err_ch !== 3'd3) begin
            miscompares++;
            $display("FAIL mis_hold: got state=%0d err=%0b ch=%0d, want 4 1 3", state, err, err_ch);
        end
        end_session();
    endtask

    task automatic test_overflow();
        start_session();
        for (int k = 0; k < 5; k++) begin
            clear_inputs();
            set_dut(1, 32'h100 + k);
            tick();
        end
        clear_inputs();
        vectors++;
        if (state !== 3'd4 || err_code !== 3'd2 || err_ch !== 3'd1) begin
            miscompares++;
            $display("FAIL ovf_capture: got state=%0d code=%0d ch=%0d, want 4 2 1",
                     state, err_code, err_ch);
        end
        vectors++;
        if (err_dut_val !== 32'h100 || err_mdl_val !== 32'h0 || err_cycle !== 32'd4) begin
            miscompares++;
            $display("FAIL ovf_values: got dut=%0h mdl=%0h cyc=%0d, want 100 0 4",
                     err_dut_val, err_mdl_val, err_cycle);
        end
        end_session();
    endtask

    task automatic test_timeout();
        start_session();
        repeat (16) tick();
        vectors++;
        if (state !== 3'd1) begin
            miscompares++;
            $display("FAIL tmo_pre_state: got %0d, want 1", state);
        end
        tick();
        vectors++;
        if (state !== 3'd4 || err_code !== 3'd3 || err_cycle !== 32'd16 || err_ch !== 3'd0) begin
            miscompares++;
            $display("FAIL tmo_capture: got state=%0d code=%0d cyc=%0d ch=%0d, want 4 3 16 0",
                     state, err_code, err_cycle, err_ch);
        end
        end_session();
    endtask

    task automatic test_orphan();
        start_session();
        set_dut(0, 32'h77);
        bus.dut_hlt = 1'b1;
        bus.mdl_hlt = 1'b1;
        tick();
        clear_inputs();
        tick();
        vectors++;
        if (state !== 3'd2) begin
            miscompares++;
            $display("FAIL orph_drain: got state=%0d, want 2", state);
        end
        tick();
        vectors++;
        if (state !== 3'd4 || err_code !== 3'd4 || err_ch !== 3'd0 || err_cycle !== 32'd2) begin
            miscompares++;
            $display("FAIL orph_capture: got state=%0d code=%0d ch=%0d cyc=%0d, want 4 4 0 2",
                     state, err_code, err_ch, err_cycle);
        end
        vectors++;
        if (err_dut_val !== 32'h77 || err_mdl_val !== 32'h0) begin
            miscompares++;
            $display("FAIL orph_values: got dut=%0h mdl=%0h, want 77 0", err_dut_val, err_mdl_val);
        end
        end_session();
    endtask

    task automatic test_abort();
        start_session();
        vectors++;
        if (err_code !== 3'd0 || err_cycle !== 32'd0) begin
            miscompares++;
            $display("FAIL abort_cleared: got code=%0d cyc=%0d, want 0 0", err_code, err_cycle);
        end
        set_dut(4, 32'h9);
        tick();
        end_session();
        vectors++;
        if (state !== 3'd0 || err !== 1'b0 || done !== 1'b0 || err_code !== 3'd0) begin
            miscompares++;
            $display("FAIL abort_idle: got state=%0d err=%0b done=%0b code=%0d, want 0 0 0 0",
                     state, err, done, err_code);
        end
        // The stale ch4 entry must not survive into the next session.
        start_session();
        bus.dut_hlt = 1'b1;
        bus.mdl_hlt = 1'b1;
        tick();
        clear_inputs();
        tick();
        tick();
        vectors++;
        if (state !== 3'd3 || pass !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_flush: got state=%0d pass=%0b, want 3 1", state, pass);
        end
        end_session();
    endtask

    task automatic test_reset_mid_run();
        start_session();
        set_dut(0, 32'h55);
        set_mdl(0, 32'h55);
        tick();
        clear_inputs();
        tick();
        vectors++;
        if (cmp_count !== 32'd1 || state !== 3'd1) begin
            miscompares++;
            $display("FAIL rst_pre: got cnt=%0d state=%0d, want 1 1", cmp_count, state);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (state !== 3'd0 || cmp_count !== 32'd0 || done !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async: got state=%0d cnt=%0d done=%0b err=%0b, want 0 0 0 0",
                     state, cmp_count, done, err);
        end
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish, want finish before 200000");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        test_reset();
        test_matched();
        test_multi_channel();
        test_skew();
        test_mismatch();
        test_overflow();
        test_timeout();
        test_orphan();
        test_abort();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
